// File: rtl/linebuffer_3x3_mc_pkg.sv
// Shared constants, state type and frame-width table
// for the multi-channel 3x3 line buffer.
package linebuffer_3x3_mc_pkg;

   localparam int LEN1    = 8;
   localparam int LEN2    = 14;
   localparam int LEN3    = 28;
   localparam int LEN4    = 56;
   localparam int LEN5    = 112;
   localparam int LEN6    = 224;
   localparam int LEN_MAX = LEN6;
   localparam int TAPS    = 9;
   localparam int CW      = $clog2(LEN_MAX);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   // Codes 6 and 7 fall back to the smallest frame.
   function automatic logic [CW-1:0] frame_len(input logic [2:0] sel);
      logic [CW-1:0] w;
      unique case (sel)
         3'd0:    w = CW'(LEN1);
         3'd1:    w = CW'(LEN2);
         3'd2:    w = CW'(LEN3);
         3'd3:    w = CW'(LEN4);
         3'd4:    w = CW'(LEN5);
         3'd5:    w = CW'(LEN6);
         default: w = CW'(LEN1);
      endcase
      return w;
   endfunction

endpackage

// File: rtl/linebuffer_3x3_ch.sv
// One channel: two line memories plus the
// three 3-deep column shift registers of the window.
module linebuffer_3x3_ch
   import linebuffer_3x3_mc_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = LEN_MAX
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [CW-1:0]      addr,
   input  logic [DW-1:0]      din,
   output logic [TAPS*DW-1:0] win
);

   logic [DW-1:0] line0 [DEPTH];
   logic [DW-1:0] line1 [DEPTH];
   logic [DW-1:0] sr    [3][3];
   logic [DW-1:0] top;
   logic [DW-1:0] mid;

   assign top = line1[addr];
   assign mid = line0[addr];

   // Age the column: line0 moves up into line1, new pixel into line0.
   always_ff @(posedge clk) begin
      if (en) begin
         line1[addr] <= line0[addr];
         line0[addr] <= din;
      end
   end

   // Shift each window row left; newest column enters at j=2.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 3; r++)
            for (int j = 0; j < 3; j++)
               sr[r][j] <= '0;
      end else if (en) begin
         for (int r = 0; r < 3; r++) begin
            sr[r][0] <= sr[r][1];
            sr[r][1] <= sr[r][2];
         end
         sr[0][2] <= top;
         sr[1][2] <= mid;
         sr[2][2] <= din;
      end
   end

   // Flatten taps as k = 3*row + column.
   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++)
         for (int j = 0; j < 3; j++)
            win[(3*r+j)*DW +: DW] = sr[r][j];
   end

endmodule

// File: rtl/linebuffer_3x3_mc.sv
// Multi-channel 3x3 sliding-window generator with
// per-frame width/stride latch and valid/done flags.
module linebuffer_3x3_mc
   import linebuffer_3x3_mc_pkg::*;
#(
   parameter int CH = 8,
   parameter int DW = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              sel,
   input  logic                    stride2,
   input  logic                    in_valid,
   input  logic [CH*DW-1:0]        in_data,
   output logic                    win_valid,
   output logic [CH*TAPS*DW-1:0]   win_data,
   output logic                    frame_done
);

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] col;
   logic [CW-1:0] row;
   logic [CW-1:0] cfg_w;
   logic          cfg_s2;
   logic [CW-1:0] cur_w;
   logic          cur_s2;
   logic          col_end;
   logic          last;
   logic          emit;
   logic          en;

   assign en = in_valid && !rst;

   // In IDLE the live inputs configure the opening beat itself.
   always_comb begin
      cur_w  = cfg_w;
      cur_s2 = cfg_s2;
      if (state == IDLE) begin
         cur_w  = frame_len(sel);
         cur_s2 = stride2;
      end
   end

   // Beat classification and next-state selection.
   always_comb begin
      state_nx = state;
      col_end  = (col == cur_w - CW'(1));
      last     = col_end && (row == cur_w - CW'(1));
      emit     = (row >= CW'(2)) && (col >= CW'(2)) &&
                 (!cur_s2 || (!row[0] && !col[0]));
      unique case (state)
         IDLE:   if (in_valid) state_nx = ACTIVE;
         ACTIVE: if (in_valid && last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Raster position of the next accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (col_end) begin
            col <= '0;
            row <= last ? '0 : row + CW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Capture frame width and stride on the opening beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_w  <= CW'(LEN1);
         cfg_s2 <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         cfg_w  <= frame_len(sel);
         cfg_s2 <= stride2;
      end
   end

   // Registered window-valid and end-of-frame flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= in_valid && emit;
         frame_done <= in_valid && last;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      linebuffer_3x3_ch #(
         .DW    (DW),
         .DEPTH (LEN_MAX)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .addr (col),
         .din  (in_data[c*DW +: DW]),
         .win  (win_data[c*TAPS*DW +: TAPS*DW])
      );
   end

endmodule

// File: tb/tb_linebuffer_3x3_mc.sv
// Scoreboard bench for linebuffer_3x3_mc: directed frames
// with expected windows queued at issue time.
module tb_linebuffer_3x3_mc;
   import linebuffer_3x3_mc_pkg::*;

   localparam int CH = 8;
   localparam int DW = 8;
   localparam int WD = CH*TAPS*DW;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    sel;
   logic          stride2;
   logic          in_valid;
   logic [CH*DW-1:0] in_data;
   logic          win_valid;
   logic [WD-1:0] win_data;
   logic          frame_done;

   typedef struct {
      logic [WD-1:0] data;
      int            cyc;
   } exp_t;

   exp_t win_q[$];
   int   done_q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   int   win_cnt  = 0;
   int   done_cnt = 0;
   int   wbase    = 0;
   int   dbase    = 0;

   linebuffer_3x3_mc #(.CH(CH), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .sel        (sel),
      .stride2    (stride2),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .win_valid  (win_valid),
      .win_data   (win_data),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic cmp(input string n, input logic [WD-1:0] a,
                      input logic [WD-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int r, input int c,
                                         input int w, input int ch);
      return DW'((r*w + c + 32*ch) % 256);
   endfunction

   // Monitor: pops expected windows/pulses and flags missing ones.
   always @(negedge clk) begin
      exp_t e;
      if (win_valid) begin
         win_cnt++;
         if (win_q.size() == 0) begin
            cmp("unexpected_window", 1, 0);
         end else begin
            e = win_q.pop_front();
            cmp("win_data", win_data, e.data);
            cmp("win_cycle", WD'(cyc), WD'(e.cyc));
         end
      end else if (win_q.size() > 0 && win_q[0].cyc <= cyc) begin
         e = win_q.pop_front();
         cmp("missing_window", 0, 1);
      end
      if (frame_done) begin
         done_cnt++;
         if (done_q.size() == 0) cmp("unexpected_done", 1, 0);
         else cmp("done_cycle", WD'(cyc), WD'(done_q.pop_front()));
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
         void'(done_q.pop_front());
         cmp("missing_done", 0, 1);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_data  = {$urandom, $urandom};
      end
   endtask

   task automatic beat(input int r, input int c, input int w,
                       input bit s2, input logic [2:0] s);
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1;
      sel      = s;
      stride2  = s2;
      for (int ch = 0; ch < CH; ch++)
         in_data[ch*DW +: DW] = pix(r, c, w, ch);
      if (r >= 2 && c >= 2 && (!s2 || (r % 2 == 0 && c % 2 == 0))) begin
         e.data = '0;
         for (int ch = 0; ch < CH; ch++)
            for (int rr = 0; rr < 3; rr++)
               for (int j = 0; j < 3; j++)
                  e.data[(ch*TAPS + 3*rr + j)*DW +: DW] =
                     pix(r-2+rr, c-2+j, w, ch);
         e.cyc = cyc + 1;
         win_q.push_back(e);
      end
      if (r == w-1 && c == w-1) done_q.push_back(cyc + 1);
   endtask

   // One raster frame; s0 is sel on the first beat, s1 afterwards.
   // A reset replaces the beat at (ar,ac) when that position is reached.
   task automatic frame(input int w, input bit s2, input logic [2:0] s0,
                        input logic [2:0] s1, input bit gaps,
                        input int ar, input int ac);
      for (int r = 0; r < w; r++) begin
         for (int c = 0; c < w; c++) begin
            if (r == ar && c == ac) begin
               @(posedge clk); #1;
               rst      = 1'b1;
               in_valid = 1'b1;
               @(posedge clk); #1;
               rst      = 1'b0;
               in_valid = 1'b0;
               @(negedge clk);
               cmp("abort_win_valid", WD'(win_valid), 0);
               cmp("abort_frame_done", WD'(frame_done), 0);
               cmp("abort_win_data", win_data, 0);
               return;
            end
            if (gaps && $urandom_range(0, 1) == 1) idle(1);
            beat(r, c, w, s2, (r == 0 && c == 0) ? s0 : s1);
         end
      end
   endtask

   task automatic expect_count(input string n, input int wins,
                               input int dones);
      idle(3);
      @(negedge clk);
      cmp({n, "_windows"}, WD'(win_cnt - wbase), WD'(wins));
      cmp({n, "_done"}, WD'(done_cnt - dbase), WD'(dones));
      wbase = win_cnt;
      dbase = done_cnt;
   endtask

   initial begin
      rst      = 1'b1;
      sel      = 3'd0;
      stride2  = 1'b0;
      in_valid = 1'b1;
      in_data  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      cmp("reset_win_valid", WD'(win_valid), 0);
      cmp("reset_frame_done", WD'(frame_done), 0);
      cmp("reset_win_data", win_data, 0);

      frame(8, 1'b0, 3'd0, 3'd0, 1'b0, -1, -1);
      expect_count("w8_s1", 36, 1);

      frame(8, 1'b1, 3'd0, 3'd0, 1'b0, -1, -1);
      expect_count("w8_s2", 9, 1);

      frame(14, 1'b0, 3'd1, 3'd1, 1'b0, -1, -1);
      expect_count("w14_gapless", 144, 1);

      frame(14, 1'b0, 3'd1, 3'd6, 1'b1, -1, -1);
      expect_count("w14_gaps", 144, 1);

      frame(8, 1'b0, 3'd7, 3'd7, 1'b0, 3, 5);
      expect_count("w8_abort", 9, 0);
      frame(8, 1'b0, 3'd0, 3'd0, 1'b0, -1, -1);
      expect_count("w8_after_abort", 36, 1);

      frame(8, 1'b0, 3'd0, 3'd5, 1'b0, -1, -1);
      frame(224, 1'b0, 3'd5, 3'd5, 1'b0, -1, -1);
      expect_count("w8_then_w224", 36 + 222*222, 2);

      cmp("win_q_empty", WD'(win_q.size()), 0);
      cmp("done_q_empty", WD'(done_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
